// File: rtl/bicubic_stream_sequencer.sv
// bicubic_stream_sequencer: frame-locking front end for the bicubic core's AXI-Stream input.
// Defining BICUBIC_SEQ_PAD_EN builds edge-replication padding for short lines; otherwise they flush.
module bicubic_stream_sequencer #(
  parameter int IMAGE_WIDTH  = 960,
  parameter int IMAGE_HEIGHT = 540,
  parameter int PIXEL_WIDTH  = 8,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   sclr,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   frame_count,
  output logic [CNT_WIDTH-1:0]   err_count
);

  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_SOF, ACTIVE, DROP, FLUSH
`ifdef BICUBIC_SEQ_PAD_EN
    , PAD
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x, x_nxt;
  logic [YW-1:0]   y, y_nxt;
  logic [FW-1:0]   flush_cnt;
  logic            fwd, accept, pad_out, err_inc, frame_inc, line_done;
  logic            x_last, at_origin, short_line;

  assign x_last     = (x == X_LAST);
  assign at_origin  = (x == '0) && (y == '0);
  // tuser at a non-origin position is handled as early SOF before tlast is considered
  assign short_line = s_axis_tlast && !x_last && !s_axis_tuser;

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    fwd       = 1'b0;
    accept    = 1'b0;
    pad_out   = 1'b0;
    err_inc   = 1'b0;
    frame_inc = 1'b0;
    line_done = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = WAIT_SOF;
      WAIT_SOF: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (s_axis_tuser) begin
          fwd = 1'b1;
          if (s_axis_tvalid && m_axis_tready) begin
            x_nxt     = XW'(1);
            state_nxt = ACTIVE;
          end
        end else begin
          accept = 1'b1;
        end
      end
      ACTIVE: begin
        if (s_axis_tuser && !at_origin) begin
          if (s_axis_tvalid) begin
            err_inc   = 1'b1;
            state_nxt = FLUSH;
          end
        end else if (short_line) begin
`ifdef BICUBIC_SEQ_PAD_EN
          fwd = 1'b1;
          if (s_axis_tvalid && m_axis_tready) begin
            err_inc   = 1'b1;
            x_nxt     = x + 1'b1;
            state_nxt = PAD;
          end
`else
          accept = 1'b1;
          if (s_axis_tvalid) begin
            err_inc   = 1'b1;
            state_nxt = FLUSH;
          end
`endif
        end else begin
          fwd = 1'b1;
          if (s_axis_tvalid && m_axis_tready) begin
            if (!x_last) begin
              x_nxt = x + 1'b1;
            end else if (s_axis_tlast) begin
              line_done = 1'b1;
            end else begin
              err_inc   = 1'b1;
              state_nxt = DROP;
            end
          end
        end
      end
`ifdef BICUBIC_SEQ_PAD_EN
      PAD: begin
        pad_out = 1'b1;
        if (m_axis_tready) begin
          if (x_last) line_done = 1'b1;
          else        x_nxt = x + 1'b1;
        end
      end
`endif
      DROP: begin
        // an SOF here is left pending so it can open the next frame after the flush
        if (s_axis_tvalid && s_axis_tuser) begin
          state_nxt = FLUSH;
        end else begin
          accept = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) line_done = 1'b1;
        end
      end
      FLUSH: if (flush_cnt == F_LAST) state_nxt = WAIT_SOF;
      default: state_nxt = IDLE;
    endcase

    if (line_done) begin
      x_nxt = '0;
      if (y == Y_LAST) begin
        y_nxt     = '0;
        frame_inc = 1'b1;
        state_nxt = enable ? WAIT_SOF : IDLE;
      end else begin
        y_nxt     = y + 1'b1;
        state_nxt = ACTIVE;
      end
    end
    if (state_nxt == FLUSH) begin
      x_nxt = '0;
      y_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      flush_cnt   <= '0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (frame_inc) frame_count <= frame_count + 1'b1;
      if (err_inc && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

`ifdef BICUBIC_SEQ_PAD_EN
  logic [PIXEL_WIDTH-1:0] held;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) held <= '0;
    else if (state == ACTIVE && short_line && fwd && s_axis_tvalid && m_axis_tready) held <= s_axis_tdata;
  end

  assign m_axis_tdata = pad_out ? held : s_axis_tdata;
  assign busy         = (state == ACTIVE) || (state == PAD) || (state == DROP);
`else
  assign m_axis_tdata = s_axis_tdata;
  assign busy         = (state == ACTIVE) || (state == DROP);
`endif

  assign s_axis_tready = accept || (fwd && m_axis_tready);
  assign m_axis_tvalid = pad_out || (fwd && s_axis_tvalid);
  assign m_axis_tuser  = m_axis_tvalid && at_origin;
  assign m_axis_tlast  = m_axis_tvalid && x_last;
  assign sclr          = (state == FLUSH);

endmodule

// File: tb/tb_bicubic_stream_sequencer.sv
// tb_bicubic_stream_sequencer: randomized stream bench for bicubic_stream_sequencer (8x4 frames).
// Expected output is derived by a beat-list model that walks a linear pixel index through the frame.
module tb_bicubic_stream_sequencer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int FC = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       user;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tuser;
  logic       m_axis_tlast;
  logic       m_axis_tready = 1'b0;
  logic       sclr;
  logic       busy;
  logic [15:0] frame_count;
  logic [15:0] err_count;

  beat_t stim_q[$], src_q[$], out_q[$], exp_q[$];
  int    sclr_runs[$];
  int    exp_err_total, exp_frame_total, exp_flushes;
  int    checks = 0;
  int    errors = 0;
  bit    timed_out;

  bicubic_stream_sequencer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(8), .FLUSH_CYCLES(FC), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .sclr(sclr), .busy(busy), .frame_count(frame_count), .err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic beat_t mk(input logic [7:0] d, input logic u, input logic l);
    beat_t b;
    b.data = d;
    b.user = u;
    b.last = l;
    return b;
  endfunction

  task automatic push_line(input int len, input bit sof, input bit eol);
    for (int i = 0; i < len; i++)
      stim_q.push_back(mk(8'($urandom), sof && (i == 0), eol && (i == len - 1)));
  endtask

  task automatic push_frame();
    for (int r = 0; r < H; r++) push_line(W, r == 0, 1'b1);
  endtask

  // Walks the input list with a linear index p = row*W + col into the current frame.
  task automatic run_model();
    int    p = 0;
    int    i = 0;
    bit    synced = 0;
    bit    dropping = 0;
    beat_t b;
    exp_q.delete();
    exp_flushes = 0;
    while (i < stim_q.size()) begin
      b = stim_q[i];
      if (!synced) begin
        i++;
        if (b.user) begin
          synced = 1;
          exp_q.push_back(mk(b.data, 1'b1, 1'b0));
          p = 1;
        end
      end else if (dropping) begin
        if (b.user) begin
          synced = 0;
          dropping = 0;
          exp_flushes++;
        end else begin
          i++;
          if (b.last) begin
            dropping = 0;
            p = (p / W + 1) * W;
          end
        end
      end else if (b.user) begin
        exp_err_total++;
        exp_flushes++;
        synced = 0;
      end else if (b.last && (p % W != W - 1)) begin
        exp_err_total++;
        i++;
`ifdef BICUBIC_SEQ_PAD_EN
        while (p % W != W - 1) begin
          exp_q.push_back(mk(b.data, 1'b0, 1'b0));
          p++;
        end
        exp_q.push_back(mk(b.data, 1'b0, 1'b1));
        p++;
`else
        exp_flushes++;
        synced = 0;
`endif
      end else begin
        i++;
        exp_q.push_back(mk(b.data, p == 0, p % W == W - 1));
        if ((p % W == W - 1) && !b.last) begin
          exp_err_total++;
          dropping = 1;
        end else begin
          p++;
        end
      end
      if (synced && !dropping && p == W * H) begin
        exp_frame_total++;
        synced = 0;
      end
    end
  endtask

  // Source holds a presented beat until it transfers; sink ready is random when throttled.
  task automatic run_stream(input bit throttle, input int drop_after, input int max_cycles);
    bit s_xfer, m_xfer;
    bit hold = 0;
    int run = 0;
    src_q = stim_q;
    out_q.delete();
    sclr_runs.delete();
    timed_out = 1;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (!hold) s_axis_tvalid = (src_q.size() > 0) && (!throttle || $urandom_range(0, 3) != 0);
      if (src_q.size() > 0) {s_axis_tdata, s_axis_tuser, s_axis_tlast} = src_q[0];
      else {s_axis_tdata, s_axis_tuser, s_axis_tlast} = '0;
      m_axis_tready = !throttle || ($urandom_range(0, 2) != 0);
      if (drop_after >= 0 && out_q.size() >= drop_after) enable = 1'b0;
      @(negedge clk);
      s_xfer = s_axis_tvalid && s_axis_tready;
      m_xfer = m_axis_tvalid && m_axis_tready;
      if (m_xfer) out_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
      if (sclr) run++;
      else if (run > 0) begin
        sclr_runs.push_back(run);
        run = 0;
      end
      hold = s_axis_tvalid && !s_xfer;
      @(posedge clk);
      #1;
      if (s_xfer) void'(src_q.pop_front());
      if (!busy && !sclr && (src_q.size() == 0 || !enable)) begin
        timed_out = 0;
        break;
      end
    end
    if (run > 0) sclr_runs.push_back(run);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake got %b want 0000", {s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast});
    end
    checks++;
    if ({sclr, busy} !== 2'b0) begin
      errors++;
      $display("[TB] FAIL reset_status got sclr=%b busy=%b want 0 0", sclr, busy);
    end
    checks++;
    if (frame_count !== 16'd0 || err_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", frame_count, err_count);
    end
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    enable = 1'b1;
    exp_err_total = 0;
    exp_frame_total = 0;
  endtask

  task automatic test_clean_frame();
    stim_q.delete();
    push_frame();
    run_model();
    run_stream(1'b0, -1, 200);
    checks++;
    if (timed_out) begin errors++; $display("[TB] FAIL clean_done got timeout want idle"); end
    checks++;
    if (out_q.size() != 32) begin errors++; $display("[TB] FAIL clean_len got %0d want 32", out_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL clean_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_count !== 16'd1 || err_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL clean_counters got %0d/%0d want 1/0", frame_count, err_count);
    end
  endtask

  task automatic test_throttled();
    stim_q.delete();
    push_frame();
    push_frame();
    run_model();
    run_stream(1'b1, -1, 1000);
    checks++;
    if (timed_out) begin errors++; $display("[TB] FAIL throttle_done got timeout want idle"); end
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL throttle_len got %0d want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL throttle_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_count !== 16'(exp_frame_total) || err_count !== 16'(exp_err_total)) begin
      errors++;
      $display("[TB] FAIL throttle_counters got %0d/%0d want %0d/%0d", frame_count, err_count, exp_frame_total, exp_err_total);
    end
  endtask

  task automatic test_short_line();
    beat_t b;
    stim_q.delete();
    push_line(W, 1'b1, 1'b1);
    push_line(5, 1'b0, 1'b1);
    b = stim_q.pop_back();
    b.data = 8'h55;
    stim_q.push_back(b);
    push_line(W, 1'b0, 1'b1);
    push_line(W, 1'b0, 1'b1);
    push_frame();
    run_model();
    run_stream(1'b1, -1, 1000);
    checks++;
    if (timed_out) begin errors++; $display("[TB] FAIL short_done got timeout want idle"); end
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL short_len got %0d want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL short_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_count !== 16'(exp_frame_total) || err_count !== 16'(exp_err_total)) begin
      errors++;
      $display("[TB] FAIL short_counters got %0d/%0d want %0d/%0d", frame_count, err_count, exp_frame_total, exp_err_total);
    end
    checks++;
    if (sclr_runs.size() != exp_flushes) begin errors++; $display("[TB] FAIL short_flushes got %0d want %0d", sclr_runs.size(), exp_flushes); end
    foreach (sclr_runs[i]) begin
      checks++;
      if (sclr_runs[i] != FC) begin errors++; $display("[TB] FAIL short_sclr_len got %0d want %0d", sclr_runs[i], FC); end
    end
  endtask

  task automatic test_long_line();
    stim_q.delete();
    push_line(W, 1'b1, 1'b1);
    push_line(W, 1'b0, 1'b1);
    push_line(W + 3, 1'b0, 1'b1);
    push_line(W, 1'b0, 1'b1);
    run_model();
    run_stream(1'b1, -1, 1000);
    checks++;
    if (timed_out) begin errors++; $display("[TB] FAIL long_done got timeout want idle"); end
    checks++;
    if (out_q.size() != 32) begin errors++; $display("[TB] FAIL long_len got %0d want 32", out_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL long_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_count !== 16'(exp_frame_total) || err_count !== 16'(exp_err_total)) begin
      errors++;
      $display("[TB] FAIL long_counters got %0d/%0d want %0d/%0d", frame_count, err_count, exp_frame_total, exp_err_total);
    end
    checks++;
    if (sclr_runs.size() != 0) begin errors++; $display("[TB] FAIL long_flushes got %0d want 0", sclr_runs.size()); end
  endtask

  task automatic test_early_sof();
    stim_q.delete();
    push_line(W, 1'b1, 1'b1);
    push_line(3, 1'b0, 1'b0);
    push_frame();
    run_model();
    run_stream(1'b1, -1, 1000);
    checks++;
    if (timed_out) begin errors++; $display("[TB] FAIL sof_done got timeout want idle"); end
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL sof_len got %0d want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL sof_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_count !== 16'(exp_frame_total) || err_count !== 16'(exp_err_total)) begin
      errors++;
      $display("[TB] FAIL sof_counters got %0d/%0d want %0d/%0d", frame_count, err_count, exp_frame_total, exp_err_total);
    end
    checks++;
    if (sclr_runs.size() != 1) begin errors++; $display("[TB] FAIL sof_flushes got %0d want 1", sclr_runs.size()); end
    foreach (sclr_runs[i]) begin
      checks++;
      if (sclr_runs[i] != FC) begin errors++; $display("[TB] FAIL sof_sclr_len got %0d want %0d", sclr_runs[i], FC); end
    end
  endtask

  task automatic test_random_errors();
    int r;
    stim_q.delete();
    for (int f = 0; f < 4; f++)
      for (int row = 0; row < H; row++) begin
        r = $urandom_range(0, 9);
        push_line((r < 6) ? W : $urandom_range(1, W + 3), row == 0, r != 9);
      end
    push_frame();
    run_model();
    run_stream(1'b1, -1, 4000);
    checks++;
    if (timed_out) begin errors++; $display("[TB] FAIL rand_done got timeout want idle"); end
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand_len got %0d want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_count !== 16'(exp_frame_total) || err_count !== 16'(exp_err_total)) begin
      errors++;
      $display("[TB] FAIL rand_counters got %0d/%0d want %0d/%0d", frame_count, err_count, exp_frame_total, exp_err_total);
    end
    checks++;
    if (sclr_runs.size() != exp_flushes) begin errors++; $display("[TB] FAIL rand_flushes got %0d want %0d", sclr_runs.size(), exp_flushes); end
    foreach (sclr_runs[i]) begin
      checks++;
      if (sclr_runs[i] != FC) begin errors++; $display("[TB] FAIL rand_sclr_len got %0d want %0d", sclr_runs[i], FC); end
    end
  endtask

  task automatic test_enable_drop();
    stim_q.delete();
    push_frame();
    run_model();
    push_frame();
    run_stream(1'b0, 10, 500);
    checks++;
    if (timed_out) begin errors++; $display("[TB] FAIL endrop_done got timeout want idle"); end
    checks++;
    if (out_q.size() != 32) begin errors++; $display("[TB] FAIL endrop_len got %0d want 32", out_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL endrop_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    s_axis_tvalid = 1'b1;
    s_axis_tuser = 1'b1;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL endrop_idle got rdy/vld/busy=%b want 000", {s_axis_tready, m_axis_tvalid, busy});
    end
    checks++;
    if (frame_count !== 16'(exp_frame_total)) begin
      errors++;
      $display("[TB] FAIL endrop_frames got %0d want %0d", frame_count, exp_frame_total);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    enable = 1'b1;
    stim_q.delete();
    push_frame();
    run_stream(1'b0, -1, 12);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy got %b want 1", busy); end
    s_axis_tvalid = 1'b1;
    s_axis_tuser = 1'b1;
    s_axis_tlast = 1'b1;
    m_axis_tready = 1'b1;
    aresetn = 1'b0;
    exp_err_total = 0;
    exp_frame_total = 0;
    @(negedge clk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, sclr, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs got %b want 000000", {s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, sclr, busy});
    end
    checks++;
    if (frame_count !== 16'd0 || err_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midrst_counters got %0d/%0d want 0/0", frame_count, err_count);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    aresetn = 1'b1;
    stim_q.delete();
    push_frame();
    run_model();
    run_stream(1'b1, -1, 1000);
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL recover_len got %0d want %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL recover_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++;
    if (frame_count !== 16'd1 || err_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL recover_counters got %0d/%0d want 1/0", frame_count, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_throttled();
    test_short_line();
    test_long_line();
    test_early_sof();
    test_random_errors();
    test_enable_drop();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
